packet_serializer: RTL
======================

# packet_serializer

Sink-side endpoint of the scheduler's `enable`/`consumed` handshake. It receives the packet chosen by the selector, splits it into `BEAT_SIZE`-bit beats, and sends them over a valid/ready beat stream toward the memory-side interface. When the packet has been handed off, it returns a one-cycle `consumed` pulse so the scheduler pops the selected queue and makes its next decision.

## Interface
Parameters:
- `DATA_SIZE`, default 678: width of one scheduled packet.
- `BEAT_SIZE`, default 128: width of one output beat.
- `NUM_BEATS`, derived as ceil(`DATA_SIZE`/`BEAT_SIZE`), 6 at defaults; local, not overridable.
- `INDEX_SIZE`, derived as max(1, $clog2(`NUM_BEATS`)); local.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `packet`  in  `DATA_SIZE`  selected packet from the selector.
- `activate`  in  1  scheduler `enable`; `packet` is valid while it is high.
- `consumed`  out  1  one-cycle pulse: packet taken, pop the queue.
- `beat_data`  out  `BEAT_SIZE`  current beat.
- `beat_valid`  out  1  `beat_data` is valid.
- `beat_ready`  in  1  downstream accepts the beat when `beat_valid` and `beat_ready` are both high.
- `beat_last`  out  1  high with the final beat of a packet.
- `beat_index`  out  `INDEX_SIZE`  index of the current beat, 0..`NUM_BEATS`-1.
- `busy`  out  1  high in every state except IDLE.

## Operation
- State machine: IDLE, SEND, DONE.
- IDLE:
  - If `activate` is high at a clock edge: capture `packet` into a `NUM_BEATS*BEAT_SIZE` shift register, with bits above `DATA_SIZE` zero-filled.
  - Clear the beat counter and go to SEND.
  - `activate` is ignored in every other state.
- SEND:
  - `beat_valid`=1.
  - `beat_data` = low `BEAT_SIZE` bits of the shift register.
  - `beat_index` = beat counter.
  - `beat_last` = (counter == `NUM_BEATS`-1).
  - On each accepted beat: shift right by `BEAT_SIZE` and increment the counter.
  - When the last beat is accepted, go to DONE.
- DONE: `consumed`=1 for exactly this cycle, then go to IDLE.
- Beat order is LSB first: beat k carries `packet[k*BEAT_SIZE +: BEAT_SIZE]`. The final beat is zero-padded above bit `DATA_SIZE`-1.
- Stream rule: once `beat_valid` rises, `beat_data`, `beat_index` and `beat_last` stay stable until the beat is accepted. `beat_valid` never drops without an acceptance.
- `beat_ready` may be low for any number of cycles. The block waits with no timeout.
- Upstream contract: the queue pops on the same edge that samples `consumed`, so `packet`/`activate` show the next selection by the following IDLE cycle.

## Timing
- Reset (asynchronous, while `reset`=0): state IDLE, counter 0, shift register 0. All outputs are 0 (`consumed`, `beat_data`, `beat_valid`, `beat_last`, `beat_index`, `busy`).
- Reset mid-packet: the packet is dropped, no `consumed` pulse is produced, and the block restarts in IDLE when `reset` is released.
- Latency: `activate` sampled at edge t gives beat 0 valid during cycle t+1.
- Throughput with `beat_ready` held high: `NUM_BEATS` beat cycles, plus DONE, plus IDLE. That is `NUM_BEATS`+2 cycles per packet (8 at defaults).
- `activate` high in the DONE cycle is not sampled. It is sampled again in the following IDLE cycle.
- `NUM_BEATS`=1: SEND lasts a single accepted beat with `beat_last`=1.

## Configuration
- `PACKET_SERIALIZER_EARLY_CONSUME_EN`:
  - Defined: `consumed` pulses in the first SEND cycle, i.e. the cycle right after capture. The packet is already held locally, so the queue can pop early. DONE is skipped: the last accepted beat goes straight to IDLE. Throughput is `NUM_BEATS`+1 cycles per packet.
  - Undefined: behaviour exactly as described in Operation and Timing.

## Test plan
- Single packet, ready always high: hold `activate`=1 for one IDLE cycle with `packet` bit i = i[0] (alternating 0,1 pattern).
  - Required: 6 beats, each 128'hAAAA...AAAA, in consecutive cycles with indexes 0..5.
  - Beat 5 has bits 37:0 equal to 38'h2AAAAAAAAA and bits 127:38 equal to 0, with `beat_last`=1.
  - `consumed` pulses once, 7 cycles after capture.
- Backpressure: deassert `beat_ready` for 3 cycles during beat 2. Required: beat 2 data, index and last stay stable; `consumed` is delayed by 3 cycles; no beat is duplicated or lost.
- Back-to-back: `activate` held high with two different packets. Required: the second capture happens in the IDLE cycle after DONE; the two `consumed` pulses are 8 cycles apart.
- Reset after beat 3 is accepted: pulse `reset`=0. Required: all outputs read 0 in the same cycle, no `consumed` pulse, and the next packet starts again at beat index 0.
- With `PACKET_SERIALIZER_EARLY_CONSUME_EN` and ready always high: `consumed` pulses in the cycle with `beat_index`=0; consecutive captures are 7 cycles apart.
- `activate` pulsed high during SEND and DONE only. Required: no capture happens and the current packet's beats are unaffected.

Source files
------------

// File: rtl/packet_serializer.sv
// Splits a captured packet into BEAT_SIZE-bit beats (LSB first) on a valid/ready stream
// and answers the scheduler with a one-cycle consumed pulse. Option: PACKET_SERIALIZER_EARLY_CONSUME_EN.
module packet_serializer #(
    parameter int  DATA_SIZE  = 678,
    parameter int  BEAT_SIZE  = 128,
    localparam int NUM_BEATS  = (DATA_SIZE + BEAT_SIZE - 1) / BEAT_SIZE,
    localparam int INDEX_SIZE = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
    localparam int TOTAL_SIZE = NUM_BEATS * BEAT_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_SIZE-1:0]  packet,
    input  logic                  activate,
    output logic                  consumed,
    output logic [BEAT_SIZE-1:0]  beat_data,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic                  beat_last,
    output logic [INDEX_SIZE-1:0] beat_index,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [TOTAL_SIZE-1:0]   shift_reg;
    logic [TOTAL_SIZE-1:0]   packet_ext;
    logic [INDEX_SIZE-1:0]   count_reg;
    logic                    consumed_reg;
    logic                    valid_reg;
    logic                    last_reg;
    logic                    busy_reg;

    always_comb begin
        packet_ext                = '0;
        packet_ext[DATA_SIZE-1:0] = packet;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            count_reg    <= '0;
            consumed_reg <= 1'b0;
            valid_reg    <= 1'b0;
            last_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            consumed_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (activate) begin
                        shift_reg <= packet_ext;
                        count_reg <= '0;
                        valid_reg <= 1'b1;
                        last_reg  <= (NUM_BEATS == 1);
                        busy_reg  <= 1'b1;
                        state_reg <= SEND;
`ifdef PACKET_SERIALIZER_EARLY_CONSUME_EN
                        // Packet is held locally from here on, so the queue may pop now.
                        consumed_reg <= 1'b1;
`endif
                    end
                end
                SEND: begin
                    if (beat_ready) begin
                        shift_reg <= shift_reg >> BEAT_SIZE;
                        if (last_reg) begin
                            count_reg <= '0;
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
`ifdef PACKET_SERIALIZER_EARLY_CONSUME_EN
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
`else
                            consumed_reg <= 1'b1;
                            state_reg    <= DONE;
`endif
                        end else begin
                            count_reg <= count_reg + INDEX_SIZE'(1);
                            last_reg  <= (count_reg == INDEX_SIZE'(NUM_BEATS - 2));
                        end
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign consumed   = consumed_reg;
    assign beat_data  = shift_reg[BEAT_SIZE-1:0];
    assign beat_valid = valid_reg;
    assign beat_last  = last_reg;
    assign beat_index = count_reg;
    assign busy       = busy_reg;

endmodule
